sram_frame_ctrl: RTL and testbench

Sequences the single-port async frame-buffer SRAM between two phases: image LOAD (words streamed in through a valid/ready write port) and DISPLAY (pixel reads paced by the VGA controller's active-region strobe). It owns the SRAM address counter and the CE_n/OE_n/WE_n strobes, guarantees write/read exclusivity, and hands registered pixel data to the VGA colour path. It sits between the loader (UART/host) front end, the VGA timing generator and the SRAM pins.

---
 rtl/sram_ctrl_pkg.sv | 20 ++
 rtl/sram_addr_gen.sv | 40 ++++
 rtl/sram_frame_ctrl.sv | 142 ++++++++++++++
 tb/tb_sram_frame_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the frame-buffer SRAM controller.
// Holds the controller state enum and the frame-size helper used for address wrap.
package sram_ctrl_pkg;

    localparam int DEF_ADDR_WIDTH = 20;
    localparam int DEF_DATA_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_WAIT,
        ST_WR_PULSE,
        ST_WR_HOLD,
        ST_DISPLAY
    } state_e;

    function automatic longint frame_words(input int n, input int m);
        return longint'(n) * longint'(m);
    endfunction

endpackage

// File: rtl/sram_addr_gen.sv
// SRAM address counter shared by the load and display phases.
// Clear has priority over increment; increment past i_wrap_at returns to zero.
module sram_addr_gen
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clear,
    input  logic                  i_incr,
    input  logic [ADDR_WIDTH-1:0] i_wrap_at,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_at_wrap
);

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;

    always_comb begin
        addr_d = addr_q;
        if (i_clear) begin
            addr_d = '0;
        end else if (i_incr) begin
            addr_d = (addr_q == i_wrap_at) ? '0 : addr_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign o_addr    = addr_q;
    assign o_at_wrap = (addr_q == i_wrap_at);

endmodule

// File: rtl/sram_frame_ctrl.sv
// Frame-buffer SRAM sequencer: loads a full frame through a valid/ready port,
// then streams pixels to the VGA path with one cycle of read latency.
module sram_frame_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int N          = 640,
    parameter int M          = 480
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load_start,
    input  logic                  i_wr_valid,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_wr_ready,
    input  logic                  i_active,
    input  logic                  i_frame_start,
    output logic [DATA_WIDTH-1:0] o_pix_data,
    output logic                  o_pix_valid,
    output logic                  o_load_done,
    output logic [ADDR_WIDTH-1:0] o_sram_addr,
    output logic [DATA_WIDTH-1:0] o_sram_dq,
    output logic                  o_sram_dq_oe,
    input  logic [DATA_WIDTH-1:0] i_sram_dq,
    output logic                  o_sram_ce_n,
    output logic                  o_sram_oe_n,
    output logic                  o_sram_we_n
);

    localparam longint FRAME_WORDS = frame_words(N, M);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_WORDS - 1);

    if ((FRAME_WORDS < 1) || (FRAME_WORDS > (longint'(1) << ADDR_WIDTH))) begin : g_bad_frame_size
        $error("sram_frame_ctrl: N*M does not fit the SRAM address space");
    end

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] dq_q, dq_d;
    logic [DATA_WIDTH-1:0] pix_data_q, pix_data_d;
    logic                  pix_valid_q, pix_valid_d;
    logic                  load_done_q, load_done_d;
    logic                  addr_clear;
    logic                  addr_incr;
    logic                  addr_at_last;

    sram_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (addr_clear),
        .i_incr    (addr_incr),
        .i_wrap_at (LAST_ADDR),
        .o_addr    (o_sram_addr),
        .o_at_wrap (addr_at_last)
    );

    always_comb begin
        state_d     = state_q;
        dq_d        = dq_q;
        pix_data_d  = pix_data_q;
        pix_valid_d = 1'b0;
        load_done_d = 1'b0;
        addr_clear  = 1'b0;
        addr_incr   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_load_start) begin
                    addr_clear = 1'b1;
                    state_d    = ST_WR_WAIT;
                end
            end
            ST_WR_WAIT: begin
                if (i_wr_valid) begin
                    dq_d    = i_wr_data;
                    state_d = ST_WR_PULSE;
                end
            end
            ST_WR_PULSE: begin
                state_d = ST_WR_HOLD;
            end
            // The counter wraps to zero on the last word, which also rewinds display.
            ST_WR_HOLD: begin
                addr_incr = 1'b1;
                if (addr_at_last) begin
                    load_done_d = 1'b1;
                    state_d     = ST_DISPLAY;
                end else begin
                    state_d = ST_WR_WAIT;
                end
            end
            ST_DISPLAY: begin
                if (i_load_start) begin
                    addr_clear = 1'b1;
                    state_d    = ST_WR_WAIT;
                end else begin
                    if (i_active) begin
                        pix_data_d  = i_sram_dq;
                        pix_valid_d = 1'b1;
                    end
                    if (i_frame_start) begin
                        addr_clear = 1'b1;
                    end else if (i_active) begin
                        addr_incr = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            dq_q        <= '0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dq_q        <= dq_d;
            pix_data_q  <= pix_data_d;
            pix_valid_q <= pix_valid_d;
            load_done_q <= load_done_d;
        end
    end

    // Strobes decode straight from the state register so reset releases the bus instantly.
    assign o_sram_ce_n  = (state_q == ST_IDLE);
    assign o_sram_oe_n  = (state_q != ST_DISPLAY);
    assign o_sram_we_n  = (state_q != ST_WR_PULSE);
    assign o_sram_dq_oe = (state_q == ST_WR_PULSE) || (state_q == ST_WR_HOLD);
    assign o_wr_ready   = (state_q == ST_WR_WAIT);
    assign o_sram_dq    = dq_q;
    assign o_pix_data   = pix_data_q;
    assign o_pix_valid  = pix_valid_q;
    assign o_load_done  = load_done_q;

endmodule

// File: tb/tb_sram_frame_ctrl.sv
// Directed bench for sram_frame_ctrl on a 4x2 frame with a behavioural async SRAM.
// Walks reset, two loads, display reads with wrap, frame restart and reload.
module tb_sram_frame_ctrl;

    localparam int AW = 20;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          loadStart;
    logic          wrValid;
    logic [DW-1:0] wrData;
    logic          wrReady;
    logic          active;
    logic          frameStart;
    logic [DW-1:0] pixData;
    logic          pixValid;
    logic          loadDone;
    logic [AW-1:0] sramAddr;
    logic [DW-1:0] sramDqOut;
    logic          sramDqOe;
    logic [DW-1:0] sramDqIn;
    logic          sramCeN;
    logic          sramOeN;
    logic          sramWeN;

    logic [DW-1:0] mem [0:7];
    int            writeCount;
    logic          clearModel = 1'b0;
    int            checks = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    sram_frame_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .N          (4),
        .M          (2)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_load_start  (loadStart),
        .i_wr_valid    (wrValid),
        .i_wr_data     (wrData),
        .o_wr_ready    (wrReady),
        .i_active      (active),
        .i_frame_start (frameStart),
        .o_pix_data    (pixData),
        .o_pix_valid   (pixValid),
        .o_load_done   (loadDone),
        .o_sram_addr   (sramAddr),
        .o_sram_dq     (sramDqOut),
        .o_sram_dq_oe  (sramDqOe),
        .i_sram_dq     (sramDqIn),
        .o_sram_ce_n   (sramCeN),
        .o_sram_oe_n   (sramOeN),
        .o_sram_we_n   (sramWeN)
    );

    // Behavioural SRAM: a write lands at the clock edge that closes a low WE_n cycle.
    always @(posedge clk) begin
        if (clearModel) begin
            for (int i = 0; i < 8; i++) mem[i] <= '0;
            writeCount <= 0;
        end else if (!sramWeN && !sramCeN && sramDqOe) begin
            mem[sramAddr[2:0]] <= sramDqOut;
            writeCount         <= writeCount + 1;
        end
    end

    assign sramDqIn = (!sramCeN && !sramOeN) ? mem[sramAddr[2:0]] : 16'hDEAD;

    always @(negedge clk) begin
        checks++;
        assert ((sramDqOe & ~sramOeN) === 1'b0) else begin
            failures++;
            $error("[TB] FAIL busContention observed dq_oe=%b oe_n=%b expected no overlap", sramDqOe, sramOeN);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ls, input logic wv, input logic [DW-1:0] wd,
                                 input logic act, input logic fs);
        loadStart  = ls;
        wrValid    = wv;
        wrData     = wd;
        active     = act;
        frameStart = fs;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, '0, 0, 0);
        tick();
        tick();
        checkOutput("rst_addr", sramAddr, 0);
        checkOutput("rst_ce_n", sramCeN, 1);
        checkOutput("rst_oe_n", sramOeN, 1);
        checkOutput("rst_we_n", sramWeN, 1);
        checkOutput("rst_dq_oe", sramDqOe, 0);
        checkOutput("rst_dq", sramDqOut, 0);
        checkOutput("rst_ready", wrReady, 0);
        checkOutput("rst_pix", pixData, 0);
        checkOutput("rst_pix_valid", pixValid, 0);
        checkOutput("rst_done", loadDone, 0);
        rst = 1'b0;
        tick();

        $display("[TB] reset in the middle of a write pulse");
        applyStimulus(1, 0, '0, 0, 0);
        tick();
        checkOutput("s1_ready", wrReady, 1);
        checkOutput("s1_ce_n", sramCeN, 0);
        applyStimulus(0, 1, 16'hAAAA, 0, 0);
        tick();
        checkOutput("s1_pulse_we_n", sramWeN, 0);
        checkOutput("s1_pulse_dq_oe", sramDqOe, 1);
        rst = 1'b1;
        #1;
        checkOutput("s1_rst_we_n", sramWeN, 1);
        checkOutput("s1_rst_dq_oe", sramDqOe, 0);
        checkOutput("s1_rst_addr", sramAddr, 0);
        checkOutput("s1_rst_ce_n", sramCeN, 1);
        checkOutput("s1_rst_ready", wrReady, 0);
        applyStimulus(0, 0, '0, 0, 0);
        tick();
        rst = 1'b0;
        clearModel = 1'b1;
        tick();
        clearModel = 1'b0;

        $display("[TB] full-rate load of 8 words");
        applyStimulus(1, 0, '0, 0, 0);
        tick();
        applyStimulus(0, 1, 16'h1000, 0, 0);
        for (int k = 0; k < 8; k++) begin
            checkOutput("s2_wait_ready", wrReady, 1);
            checkOutput("s2_wait_addr", sramAddr, k);
            checkOutput("s2_wait_we_n", sramWeN, 1);
            tick();
            checkOutput("s2_pulse_we_n", sramWeN, 0);
            checkOutput("s2_pulse_addr", sramAddr, k);
            checkOutput("s2_pulse_dq", sramDqOut, 32'h1000 + k);
            checkOutput("s2_pulse_dq_oe", sramDqOe, 1);
            checkOutput("s2_pulse_ready", wrReady, 0);
            applyStimulus(0, 1, 16'(32'h1000 + k + 1), 0, 0);
            tick();
            checkOutput("s2_hold_we_n", sramWeN, 1);
            checkOutput("s2_hold_dq_oe", sramDqOe, 1);
            checkOutput("s2_hold_addr", sramAddr, k);
            checkOutput("s2_hold_ready", wrReady, 0);
            checkOutput("s2_hold_done", loadDone, 0);
            tick();
        end
        checkOutput("s2_done_pulse", loadDone, 1);
        checkOutput("s2_done_addr", sramAddr, 0);
        checkOutput("s2_disp_oe_n", sramOeN, 0);
        checkOutput("s2_disp_ce_n", sramCeN, 0);
        checkOutput("s2_disp_dq_oe", sramDqOe, 0);
        checkOutput("s2_disp_ready", wrReady, 0);
        applyStimulus(0, 0, '0, 0, 0);
        tick();
        checkOutput("s2_done_once", loadDone, 0);
        checkOutput("s2_pix_valid_idle", pixValid, 0);
        checkOutput("s2_writes", writeCount, 8);
        for (int i = 0; i < 8; i++) checkOutput("s2_mem", mem[i], 32'h1000 + i);

        $display("[TB] display reads with wrap");
        applyStimulus(0, 0, '0, 1, 0);
        for (int j = 1; j <= 10; j++) begin
            tick();
            checkOutput("s4_pix", pixData, 32'h1000 + ((j - 1) % 8));
            checkOutput("s4_pix_valid", pixValid, 1);
            checkOutput("s4_addr", sramAddr, j % 8);
        end
        applyStimulus(0, 0, '0, 0, 0);
        tick();
        checkOutput("s4_idle_valid", pixValid, 0);
        checkOutput("s4_idle_pix_hold", pixData, 16'h1001);
        checkOutput("s4_idle_addr_hold", sramAddr, 2);

        $display("[TB] frame start at address 5");
        applyStimulus(0, 0, '0, 1, 0);
        tick();
        tick();
        tick();
        checkOutput("s5_addr5", sramAddr, 5);
        checkOutput("s5_pix4", pixData, 16'h1004);
        applyStimulus(0, 0, '0, 1, 1);
        tick();
        checkOutput("s5_fs_addr", sramAddr, 0);
        checkOutput("s5_fs_valid", pixValid, 1);
        applyStimulus(0, 0, '0, 1, 0);
        tick();
        checkOutput("s5_first_pix", pixData, 16'h1000);
        checkOutput("s5_next_addr", sramAddr, 1);

        $display("[TB] reload requested during display");
        applyStimulus(1, 0, '0, 1, 0);
        tick();
        checkOutput("s6_oe_n", sramOeN, 1);
        checkOutput("s6_pix_valid", pixValid, 0);
        checkOutput("s6_addr", sramAddr, 0);
        checkOutput("s6_ready", wrReady, 1);
        checkOutput("s6_dq_oe", sramDqOe, 0);
        applyStimulus(0, 0, '0, 0, 0);
        clearModel = 1'b1;
        tick();
        clearModel = 1'b0;
        checkOutput("s3_cleared", writeCount, 0);

        $display("[TB] load with gaps in valid");
        for (int k = 0; k < 8; k++) begin
            for (int g = 0; g < (k % 3); g++) begin
                applyStimulus((k == 4), 0, 16'hBEEF, 0, 0);
                tick();
                checkOutput("s3_gap_ready", wrReady, 1);
                checkOutput("s3_gap_we_n", sramWeN, 1);
                checkOutput("s3_gap_addr", sramAddr, k);
                checkOutput("s3_gap_dq_oe", sramDqOe, 0);
            end
            applyStimulus(0, 1, 16'(32'h1000 + k), 0, 0);
            tick();
            checkOutput("s3_pulse_we_n", sramWeN, 0);
            checkOutput("s3_pulse_addr", sramAddr, k);
            checkOutput("s3_pulse_dq", sramDqOut, 32'h1000 + k);
            applyStimulus(0, 0, 16'hBEEF, 0, 0);
            tick();
            checkOutput("s3_hold_ready", wrReady, 0);
            checkOutput("s3_hold_we_n", sramWeN, 1);
            tick();
        end
        checkOutput("s3_done_pulse", loadDone, 1);
        checkOutput("s3_done_addr", sramAddr, 0);
        tick();
        checkOutput("s3_done_once", loadDone, 0);
        checkOutput("s3_writes", writeCount, 8);
        for (int i = 0; i < 8; i++) checkOutput("s3_mem", mem[i], 32'h1000 + i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
